// File: rtl/effect_arbiter.sv
// Round-robin arbiter sharing one effect unit among N_CH mixer channels.
// One operation in flight at a time: grant, issue, wait for result or timeout, respond.
module effect_arbiter #(
   parameter int N_CH    = 4,
   parameter int TIMEOUT = 15
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic [N_CH-1:0]      req_valid,
   input  logic [24*N_CH-1:0]   req_data,
   output logic [N_CH-1:0]      req_ready,
   input  logic                 cfg_wren,
   input  logic [1:0]           cfg_addr,
   input  logic                 cfg_on,
   output logic [23:0]          eff_data,
   output logic                 eff_wren,
   output logic                 eff_on,
   input  logic [23:0]          eff_result,
   input  logic                 eff_valid,
   output logic [23:0]          resp_data,
   output logic [N_CH-1:0]      resp_valid,
   output logic                 resp_err,
   output logic                 busy
);

   localparam int IW = (N_CH > 1) ? $clog2(N_CH) : 1;
   localparam int CW = $clog2(TIMEOUT + 1);

   typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

   state_t          state_reg, state_next;
   logic [IW-1:0]   rr_ptr_reg;
   logic [IW-1:0]   owner_reg;
   logic [23:0]     data_reg;
   logic            on_reg;
   logic [23:0]     result_reg;
   logic            err_reg;
   logic [CW-1:0]   cnt_reg;
   logic [N_CH-1:0] cfg_en_reg;

   logic            gnt_found;
   logic [IW-1:0]   gnt_idx;
   logic            grant;
   logic            timeout_hit;

   // Scan downward in offset so the lowest offset from rr_ptr wins.
   always_comb begin
      gnt_found = 1'b0;
      gnt_idx   = '0;
      for (int k = N_CH - 1; k >= 0; k--) begin
         if (req_valid[(int'(rr_ptr_reg) + k) % N_CH]) begin
            gnt_found = 1'b1;
            gnt_idx   = IW'((int'(rr_ptr_reg) + k) % N_CH);
         end
      end
   end

   assign grant       = (state_reg == IDLE) && gnt_found && !reset;
   assign timeout_hit = (cnt_reg == CW'(TIMEOUT - 1));

   // FSM: state register
   always_ff @(posedge clk) begin
      if (reset) begin
         state_reg <= IDLE;
      end else begin
         state_reg <= state_next;
      end
   end

   // FSM: next-state logic
   always_comb begin
      state_next = state_reg;
      case (state_reg)
         IDLE:    if (gnt_found) state_next = ISSUE;
         ISSUE:   state_next = WAIT;
         WAIT:    if (eff_valid || timeout_hit) state_next = RESP;
         RESP:    state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   // FSM: outputs toward the effect unit and the responder
   always_comb begin
      eff_wren  = 1'b0;
      eff_data  = '0;
      eff_on    = 1'b0;
      resp_data = '0;
      resp_err  = 1'b0;
      busy      = (state_reg != IDLE);
      if (state_reg == ISSUE) begin
         eff_wren = 1'b1;
         eff_data = data_reg;
         eff_on   = on_reg;
      end
      if (state_reg == RESP) begin
         resp_data = result_reg;
         resp_err  = err_reg;
      end
   end

   generate
      for (genvar gi = 0; gi < N_CH; gi++) begin : g_ch
         assign req_ready[gi]  = grant && (int'(gnt_idx) == gi);
         assign resp_valid[gi] = (state_reg == RESP) && (int'(owner_reg) == gi);

         // Enable bit updates at the edge, so a grant in the same cycle sees the old value.
         always_ff @(posedge clk) begin
            if (reset) begin
               cfg_en_reg[gi] <= 1'b0;
            end else if (cfg_wren && (int'(cfg_addr) == gi)) begin
               cfg_en_reg[gi] <= cfg_on;
            end
         end
      end
   endgenerate

   always_ff @(posedge clk) begin
      if (reset) begin
         rr_ptr_reg <= '0;
         owner_reg  <= '0;
         data_reg   <= '0;
         on_reg     <= 1'b0;
         result_reg <= '0;
         err_reg    <= 1'b0;
         cnt_reg    <= '0;
      end else begin
         case (state_reg)
            IDLE: begin
               if (grant) begin
                  owner_reg <= gnt_idx;
                  data_reg  <= req_data[int'(gnt_idx)*24 +: 24];
                  on_reg    <= cfg_en_reg[gnt_idx];
                  if (int'(gnt_idx) == N_CH - 1) begin
                     rr_ptr_reg <= '0;
                  end else begin
                     rr_ptr_reg <= gnt_idx + IW'(1);
                  end
               end
            end
            ISSUE: begin
               cnt_reg <= '0;
            end
            WAIT: begin
               // A result on the last allowed cycle still beats the timeout.
               if (eff_valid) begin
                  result_reg <= eff_result;
                  err_reg    <= 1'b0;
               end else begin
                  cnt_reg <= cnt_reg + CW'(1);
                  if (timeout_hit) begin
                     result_reg <= '0;
                     err_reg    <= 1'b1;
                  end
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_effect_arbiter.sv
// Directed bench for effect_arbiter: table of single operations plus
// hand sequences for reset, stray valid and reset in the middle of a wait.
module tb_effect_arbiter;

   logic         clk = 1'b0;
   logic         reset;
   logic [3:0]   req_valid;
   logic [95:0]  req_data;
   logic [3:0]   req_ready;
   logic         cfg_wren;
   logic [1:0]   cfg_addr;
   logic         cfg_on;
   logic [23:0]  eff_data;
   logic         eff_wren;
   logic         eff_on;
   logic [23:0]  eff_result;
   logic         eff_valid;
   logic [23:0]  resp_data;
   logic [3:0]   resp_valid;
   logic         resp_err;
   logic         busy;

   int total = 0;
   int bad   = 0;

   logic [23:0] chan_data [4];

   effect_arbiter #(.N_CH(4), .TIMEOUT(15)) dut (
      .clk(clk), .reset(reset),
      .req_valid(req_valid), .req_data(req_data), .req_ready(req_ready),
      .cfg_wren(cfg_wren), .cfg_addr(cfg_addr), .cfg_on(cfg_on),
      .eff_data(eff_data), .eff_wren(eff_wren), .eff_on(eff_on),
      .eff_result(eff_result), .eff_valid(eff_valid),
      .resp_data(resp_data), .resp_valid(resp_valid), .resp_err(resp_err),
      .busy(busy)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [3:0]  rv;
      int          dly;      // cycles into WAIT when eff_valid is given; 0 = never
      logic [23:0] res;
      logic        cw;
      logic [1:0]  ca;
      logic        cv;
      int          ch;
      logic        eon;
      logic [23:0] rdata;
      logic        err;
      int          lat;
   } vec_t;

   vec_t tbl [13];

   task automatic chk(input string nm, input longint act, input longint exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   task automatic cfg_write(input logic [1:0] a, input logic v);
      @(negedge clk);
      cfg_wren = 1'b1; cfg_addr = a; cfg_on = v;
      @(negedge clk);
      cfg_wren = 1'b0;
   endtask

   task automatic do_op(input logic [3:0] rv, input int dly, input logic [23:0] res,
                        input logic cw, input logic [1:0] ca, input logic cv,
                        output int gch, output logic ew, output logic [23:0] ed,
                        output logic eo, output logic [3:0] rvo, output logic [23:0] rd,
                        output logic re, output int lat, output logic busy_after,
                        output logic [3:0] rv_after);
      int n;
      gch = -1; ew = 0; ed = 0; eo = 0; rvo = 0; rd = 0; re = 0; lat = -1;
      busy_after = 1'b1; rv_after = 4'hf;
      @(negedge clk);
      req_valid = rv; cfg_wren = cw; cfg_addr = ca; cfg_on = cv;
      #1;
      n = 0;
      while (req_ready == 4'b0 && n < 8) begin
         @(negedge clk); #1; n++;
      end
      if (req_ready == 4'b0) begin
         chk("grant_timeout", 0, 1);
         req_valid = 0; cfg_wren = 0;
         return;
      end
      for (int c = 0; c < 4; c++) if (req_ready[c]) gch = c;
      @(negedge clk); #1;
      req_valid = 0; cfg_wren = 0;
      ew = eff_wren; ed = eff_data; eo = eff_on;
      eff_result = res;
      for (int k = 1; k <= 40; k++) begin
         @(negedge clk); #1;
         if (resp_valid != 4'b0) begin
            lat = k + 1; rvo = resp_valid; rd = resp_data; re = resp_err;
            break;
         end
         eff_valid = (k == dly);
      end
      eff_valid = 1'b0;
      if (lat < 0) chk("resp_timeout", 0, 1);
      @(negedge clk); #1;
      busy_after = busy; rv_after = resp_valid;
   endtask

   int          gch, lat;
   logic        ew, eo, re, busy_after;
   logic [23:0] ed, rd;
   logic [3:0]  rvo, rv_after;

   initial begin
      chan_data[0] = 24'hA00001;
      chan_data[1] = 24'h7FFFFF;
      chan_data[2] = 24'h000100;
      chan_data[3] = 24'h800000;
      req_data   = {chan_data[3], chan_data[2], chan_data[1], chan_data[0]};
      reset      = 1'b1;
      req_valid  = 4'hf;
      cfg_wren   = 0; cfg_addr = 0; cfg_on = 0;
      eff_result = 24'h0; eff_valid = 0;

      //            rv      dly res         cw ca cv ch eon rdata       err lat
      tbl[0]  = '{4'b0100, 1, 24'h000080, 0, 0, 0, 2, 1, 24'h000080, 0, 3};
      tbl[1]  = '{4'b1001, 1, 24'h123000, 0, 0, 0, 3, 0, 24'h123000, 0, 3};
      tbl[2]  = '{4'b1111, 2, 24'hFFFFFF, 0, 0, 0, 0, 0, 24'hFFFFFF, 0, 4};
      tbl[3]  = '{4'b1111, 1, 24'h000001, 0, 0, 0, 1, 0, 24'h000001, 0, 3};
      tbl[4]  = '{4'b1111, 1, 24'h800000, 0, 0, 0, 2, 1, 24'h800000, 0, 3};
      tbl[5]  = '{4'b1111, 3, 24'h7FFFFF, 0, 0, 0, 3, 0, 24'h7FFFFF, 0, 5};
      tbl[6]  = '{4'b1111, 1, 24'h00ABCD, 0, 0, 0, 0, 0, 24'h00ABCD, 0, 3};
      tbl[7]  = '{4'b0010, 0, 24'h5A5A5A, 0, 0, 0, 1, 0, 24'h000000, 1, 17};
      tbl[8]  = '{4'b0101, 1, 24'h345678, 0, 0, 0, 2, 1, 24'h345678, 0, 3};
      tbl[9]  = '{4'b0011, 1, 24'h000002, 0, 0, 0, 0, 0, 24'h000002, 0, 3};
      tbl[10] = '{4'b0010, 15, 24'h0F0F0F, 0, 0, 0, 1, 0, 24'h0F0F0F, 0, 17};
      tbl[11] = '{4'b0001, 1, 24'h111111, 1, 0, 1, 0, 0, 24'h111111, 0, 3};
      tbl[12] = '{4'b0001, 1, 24'h222222, 0, 0, 0, 0, 1, 24'h222222, 0, 3};

      // Reset state, with every channel requesting while reset is held.
      repeat (3) @(negedge clk);
      #1;
      chk("rst_req_ready", req_ready, 0);
      chk("rst_eff_wren", eff_wren, 0);
      chk("rst_eff_on", eff_on, 0);
      chk("rst_eff_data", eff_data, 0);
      chk("rst_resp_valid", resp_valid, 0);
      chk("rst_resp_data", resp_data, 0);
      chk("rst_resp_err", resp_err, 0);
      chk("rst_busy", busy, 0);
      $display("reset: req_ready=%b busy=%b", req_ready, busy);
      req_valid = 0;
      reset = 1'b0;

      // Stray eff_valid while idle must be ignored.
      @(negedge clk);
      eff_valid = 1'b1; eff_result = 24'h123456;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk); #1;
         chk("stray_resp_valid", resp_valid, 0);
         chk("stray_resp_data", resp_data, 0);
         chk("stray_busy", busy, 0);
      end
      eff_valid = 1'b0;
      $display("stray valid: resp_valid=%b resp_data=%h", resp_valid, resp_data);

      cfg_write(2'd2, 1'b1);

      for (int i = 0; i < 13; i++) begin
         do_op(tbl[i].rv, tbl[i].dly, tbl[i].res, tbl[i].cw, tbl[i].ca, tbl[i].cv,
               gch, ew, ed, eo, rvo, rd, re, lat, busy_after, rv_after);
         $display("op %0d: rv=%b grant=ch%0d eff_data=%h eff_on=%b resp=%b/%h err=%b lat=%0d",
                  i, tbl[i].rv, gch, ed, eo, rvo, rd, re, lat);
         chk("grant", gch, tbl[i].ch);
         if (gch >= 0) begin
            chk("eff_wren", ew, 1);
            chk("eff_data", ed, chan_data[tbl[i].ch]);
            chk("eff_on", eo, tbl[i].eon);
            chk("resp_valid", rvo, 4'b0001 << tbl[i].ch);
            chk("resp_data", rd, tbl[i].rdata);
            chk("resp_err", re, tbl[i].err);
            chk("latency", lat, tbl[i].lat);
            chk("busy_after", busy_after, 0);
            chk("resp_one_pulse", rv_after, 0);
         end
      end

      // Reset while waiting on the effect unit, then a late eff_valid.
      @(negedge clk);
      req_valid = 4'b0100; #1;
      chk("mid_grant", req_ready, 4'b0100);
      @(negedge clk); #1;
      req_valid = 0;
      chk("mid_issue", eff_wren, 1);
      repeat (2) @(negedge clk);
      #1;
      chk("mid_busy_wait", busy, 1);
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      eff_valid = 1'b1; eff_result = 24'h777777;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk); #1;
         chk("mid_resp_valid", resp_valid, 0);
         chk("mid_resp_data", resp_data, 0);
         chk("mid_busy", busy, 0);
      end
      eff_valid = 1'b0;
      $display("reset mid-wait: resp_valid=%b busy=%b", resp_valid, busy);
      do_op(4'b1111, 1, 24'h0000AA, 0, 0, 0,
            gch, ew, ed, eo, rvo, rd, re, lat, busy_after, rv_after);
      $display("after reset op: grant=ch%0d eff_on=%b resp=%b/%h", gch, eo, rvo, rd);
      chk("post_rst_grant", gch, 0);
      chk("post_rst_eff_on", eo, 0);
      chk("post_rst_resp_data", rd, 24'h0000AA);
      chk("post_rst_latency", lat, 3);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/effect_arbiter.md
EFFECT_ARBITER -- requirements
Module: effect_arbiter

Interface
REQ-001 SHALL have parameter N_CH, default 4: number of requesting mixer channels.
REQ-002 SHALL have parameter TIMEOUT, default 15: max cycles spent in WAIT before the result is abandoned.
REQ-003 SHALL have port clk, input, 1: clock; all logic on posedge.
REQ-004 SHALL have port reset, input, 1: reset, synchronous, active-high.
REQ-005 SHALL have port req_valid, input, N_CH: per-channel sample request.
REQ-006 SHALL have port req_data, input, 24*N_CH: signed samples; channel i occupies bits [24*i+23:24*i].
REQ-007 SHALL have port req_ready, output, N_CH: one-hot grant pulse; transfer occurs when req_valid[i] and req_ready[i] are both high.
REQ-008 SHALL have port cfg_wren, input, 1: configuration write strobe.
REQ-009 SHALL have port cfg_addr, input, 2: channel index for the configuration write.
REQ-010 SHALL have port cfg_on, input, 1: effect-enable value written for channel cfg_addr.
REQ-011 SHALL have port eff_data, output, 24: sample driven to the shared effect unit.
REQ-012 SHALL have port eff_wren, output, 1: write strobe to the effect unit.
REQ-013 SHALL have port eff_on, output, 1: effect enable for the sample being issued.
REQ-014 SHALL have port eff_result, input, 24: effect unit output data.
REQ-015 SHALL have port eff_valid, input, 1: effect unit output valid.
REQ-016 SHALL have port resp_data, output, 24: result returned to the owning channel.
REQ-017 SHALL have port resp_valid, output, N_CH: one-hot result pulse.
REQ-018 SHALL have port resp_err, output, 1: high with resp_valid when the result was produced by timeout.
REQ-019 SHALL have port busy, output, 1: high in any state other than IDLE.

Function
REQ-020 SHALL implement FSM states IDLE, ISSUE, WAIT and RESP, registered, with one outstanding operation at most.
REQ-021 SHALL, in IDLE with any req_valid high, grant the first requesting channel found by scanning upward from rr_ptr with wrap-around, then move to ISSUE.
REQ-022 SHALL assert req_ready for the granted channel only, for exactly the grant cycle, and latch that channel's data, index and cfg_on bit in the same cycle.
REQ-023 SHALL set rr_ptr to (granted index + 1) mod N_CH on every grant.
REQ-024 SHALL, in ISSUE, drive eff_wren=1 for one cycle with eff_data and eff_on set to the latched values, then move to WAIT with the timeout counter cleared.
REQ-025 SHALL hold eff_wren=0 and eff_data=0 in all states other than ISSUE.
REQ-026 SHALL, in WAIT, capture eff_result when eff_valid=1 and move to RESP with the error flag cleared.
REQ-027 SHALL, in WAIT, increment the counter each cycle that eff_valid=0; when it reaches TIMEOUT, SHALL capture 0 as the result, set the error flag, and move to RESP.
REQ-028 SHALL, in RESP, pulse resp_valid[owner] for one cycle with resp_data and resp_err valid, then return to IDLE; resp_data and resp_err SHALL be 0 outside RESP.
REQ-029 SHALL ignore eff_valid in IDLE, ISSUE and RESP.
REQ-030 SHALL apply a cfg_wren write at the next clock edge; when the write coincides with a grant to the same channel, the latched enable SHALL be the old value.
REQ-031 SHALL give minimum latency grant->resp_valid of 3 cycles when eff_valid arrives 1 cycle after eff_wren.
REQ-032 SHALL not sign-modify data: eff_data equals the granted req_data slice bit-for-bit; resp_data equals eff_result bit-for-bit.

Reset
REQ-033 SHALL, on reset, set state to IDLE, rr_ptr=0, all cfg enables=0, counter=0 and all outputs (req_ready, eff_wren, eff_on, eff_data, resp_valid, resp_data, resp_err, busy) to 0.
REQ-034 SHALL, on reset asserted mid-operation, abandon the outstanding operation with no resp_valid pulse, and ignore any later eff_valid.

Verification
REQ-035 Single request: cfg ch2 on=1; req_valid=0100, data 0x000100 -> req_ready=0100 for 1 cycle; eff_wren=1, eff_on=1, eff_data=0x000100 next cycle; eff_valid with 0x000080 -> resp_valid=0100, resp_data=0x000080, resp_err=0.
REQ-036 Round-robin: req_valid=1111 held, effect always answering -> grants in order ch0, ch1, ch2, ch3, ch0, with no channel granted twice in a row.
REQ-037 Timeout: grant ch1, eff_valid held 0 -> exactly TIMEOUT=15 cycles in WAIT, then resp_valid=0010, resp_data=0, resp_err=1; state returns to IDLE.
REQ-038 Config race: cfg write ch0 on=1 in the same cycle as a ch0 grant -> eff_on=0 for that operation; the next ch0 operation has eff_on=1.
REQ-039 Reset mid-WAIT: reset pulsed 1 cycle, then eff_valid=1 -> no resp_valid pulse, busy=0, next grant goes to ch0.
REQ-040 Stray valid: eff_valid=1 in IDLE with 0x123456 -> no resp_valid pulse and resp_data stays 0.
